// File: rtl/sr_stim_checker.sv
`timescale 1ns/1ps
// Stimulus generator and checker for an SR flip-flop: resets the cell, drives an s/r pattern, compares q.
// Define SR_ILLEGAL_TEST_EN to add the s=r=1 vector with masked checking until q is re-established.
module sr_stim_checker #(
    parameter int NUM_VECTORS = 10,
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_rst,
    output logic             s_out,
    output logic             r_out,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_idx,
    output logic [CNT_W-1:0] err_count
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, INIT, DRIVE, CHECK, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      pat;
    logic [1:0]      pat_nxt;
    logic [1:0]      sr;
    logic [HC_W-1:0] hold_cnt;
    logic            exp_q;
    logic            armed;
    logic            chk_en;
    logic            mismatch;
    logic            accept;
    logic            hold_last;
    logic            vec_last;

    function automatic logic [1:0] pattern_sr(input logic [1:0] p);
        case (p)
            2'd1:    pattern_sr = 2'b01;
            2'd2:    pattern_sr = 2'b10;
`ifdef SR_ILLEGAL_TEST_EN
            2'd3:    pattern_sr = 2'b11;
`endif
            default: pattern_sr = 2'b00;
        endcase
    endfunction

    function automatic logic model_q(input logic q, input logic [1:0] sr_v);
        case (sr_v)
            2'b01:   model_q = 1'b0;
            2'b10:   model_q = 1'b1;
            default: model_q = q;
        endcase
    endfunction

`ifdef SR_ILLEGAL_TEST_EN
    logic exp_known;

    // s=r=1 leaves q undefined; only an explicit set or reset makes it predictable again
    function automatic logic known_next(input logic k, input logic [1:0] sr_v);
        case (sr_v)
            2'b11:        known_next = 1'b0;
            2'b01, 2'b10: known_next = 1'b1;
            default:      known_next = k;
        endcase
    endfunction

    assign chk_en  = exp_known;
    assign pat_nxt = pat + 2'd1;
`else
    assign chk_en  = 1'b1;
    assign pat_nxt = (pat == 2'd2) ? 2'd0 : pat + 2'd1;
`endif

    assign hold_last = (hold_cnt == HC_W'(HOLD_CYCLES - 1));
    assign vec_last  = (vec_idx == CNT_W'(NUM_VECTORS - 1));
    // armed stays low for the first edge after reset release, so a start there is dropped
    assign accept    = start && armed && ((state == IDLE) || (state == DONE));
    assign mismatch  = chk_en && (q_in != exp_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        dut_rst   = 1'b0;
        sr        = 2'b00;
        case (state)
            IDLE: begin
                if (accept) state_nxt = INIT;
            end
            INIT: begin
                busy      = 1'b1;
                dut_rst   = 1'b1;
                state_nxt = DRIVE;
            end
            DRIVE: begin
                busy = 1'b1;
                sr   = pattern_sr(pat);
                if (hold_last) state_nxt = CHECK;
            end
            CHECK: begin
                busy      = 1'b1;
                sr        = pattern_sr(pat);
                state_nxt = vec_last ? DONE : DRIVE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_nxt = INIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_out = sr[1];
    assign r_out = sr[0];
    assign pass  = done && (err_count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed     <= 1'b0;
            pat       <= 2'd0;
            hold_cnt  <= '0;
            vec_idx   <= '0;
            err_count <= '0;
            exp_q     <= 1'b0;
`ifdef SR_ILLEGAL_TEST_EN
            exp_known <= 1'b1;
`endif
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        err_count <= '0;
                        vec_idx   <= '0;
                        pat       <= 2'd0;
                    end
                end
                INIT: begin
                    hold_cnt  <= '0;
                    exp_q     <= model_q(1'b0, pattern_sr(pat));
`ifdef SR_ILLEGAL_TEST_EN
                    exp_known <= known_next(1'b1, pattern_sr(pat));
`endif
                end
                DRIVE: begin
                    if (!hold_last) hold_cnt <= hold_cnt + HC_W'(1);
                end
                CHECK: begin
                    hold_cnt <= '0;
                    if (mismatch && (err_count != '1)) err_count <= err_count + CNT_W'(1);
                    if (!vec_last) begin
                        vec_idx   <= vec_idx + CNT_W'(1);
                        pat       <= pat_nxt;
                        exp_q     <= model_q(exp_q, pattern_sr(pat_nxt));
`ifdef SR_ILLEGAL_TEST_EN
                        exp_known <= known_next(exp_known, pattern_sr(pat_nxt));
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_stim_checker.sv
`timescale 1ns/1ps
// Scoreboard bench for sr_stim_checker with behavioural SR flip-flops (good, stuck-at-0, stuck-1-after-11).
module tb_sr_stim_checker;

`ifdef SR_ILLEGAL_TEST_EN
    localparam int NI   = 3;
    localparam int NPAT = 4;
`else
    localparam int NI   = 2;
    localparam int NPAT = 3;
`endif

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       drst;
        logic       s;
        logic       r;
        logic       pass;
        logic [7:0] vec;
        logic [7:0] err;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] st, dr, so, ro, qi, bz, dn, ps;
    logic [7:0]    vo [NI];
    logic [7:0]    eo [NI];
    logic          qm [NI];
    logic          seen [NI];
    int            sel;
    int            fault;
    int            nvec;
    int            nerr;
    obs_t          cur;
    obs_t          sb [$];

    always #5 clk = ~clk;

    sr_stim_checker #(.NUM_VECTORS(10), .HOLD_CYCLES(1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .start(st[0]), .dut_rst(dr[0]), .s_out(so[0]), .r_out(ro[0]),
        .q_in(qi[0]), .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .vec_idx(vo[0]), .err_count(eo[0])
    );

    sr_stim_checker #(.NUM_VECTORS(4), .HOLD_CYCLES(3), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .dut_rst(dr[1]), .s_out(so[1]), .r_out(ro[1]),
        .q_in(qi[1]), .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .vec_idx(vo[1]), .err_count(eo[1])
    );

`ifdef SR_ILLEGAL_TEST_EN
    sr_stim_checker #(.NUM_VECTORS(8), .HOLD_CYCLES(1), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .start(st[2]), .dut_rst(dr[2]), .s_out(so[2]), .r_out(ro[2]),
        .q_in(qi[2]), .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .vec_idx(vo[2]), .err_count(eo[2])
    );
`endif

    // fault 1: q stuck at 0; fault 2: q forced to 1 once s=r=1 has been seen
    for (genvar i = 0; i < NI; i++) begin : g_ff
        initial begin
            qm[i]   = 1'b0;
            seen[i] = 1'b0;
        end
        always @(posedge clk) begin
            if (dr[i]) begin
                qm[i]   <= 1'b0;
                seen[i] <= 1'b0;
            end else begin
                if (so[i] && !ro[i]) qm[i] <= 1'b1;
                else if (ro[i] && !so[i]) qm[i] <= 1'b0;
                if (so[i] && ro[i]) seen[i] <= 1'b1;
            end
        end
        assign qi[i] = (fault == 1) ? 1'b0 : ((fault == 2 && seen[i]) ? 1'b1 : qm[i]);
    end

    assign cur = {bz[sel], dn[sel], dr[sel], so[sel], ro[sel], ps[sel], vo[sel], eo[sel]};

    task automatic build(input int n, input int h, input int fm);
        obs_t e;
        logic eq, known, sn, dq;
        int   p, err;
        eq = 1'b0; known = 1'b1; sn = 1'b0; err = 0;
        e = '0; e.busy = 1'b1; e.drst = 1'b1;
        sb.push_back(e);
        for (int v = 0; v < n; v++) begin
            p = v % NPAT;
            if (p == 1) begin eq = 1'b0; known = 1'b1; end
            else if (p == 2) begin eq = 1'b1; known = 1'b1; end
            else if (p == 3) begin known = 1'b0; sn = 1'b1; end
            for (int c = 0; c <= h; c++) begin
                e = '0; e.busy = 1'b1;
                e.s = (p == 2 || p == 3); e.r = (p == 1 || p == 3);
                e.vec = 8'(v); e.err = 8'(err);
                sb.push_back(e);
            end
            dq = (fm == 1) ? 1'b0 : ((fm == 2 && sn) ? 1'b1 : eq);
            if (known && dq != eq && err != 255) err++;
        end
        e = '0; e.done = 1'b1; e.pass = (err == 0); e.vec = 8'(n - 1); e.err = 8'(err);
        sb.push_back(e);
    endtask

    task automatic run(input string name, input int mid, input int stop_at, input logic done_before);
        obs_t e;
        int   cyc;
        st[sel] = 1'b1;
        #1;
        nvec++;
        if (cur.done !== done_before) begin
            nerr++;
            $display("FAIL %s done_in_start_cycle: got %b want %b", name, cur.done, done_before);
        end
        @(negedge clk);
        st[sel] = 1'b0;
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            nvec++;
            if (cur !== e) begin
                nerr++;
                $display("FAIL %s cyc%0d: got %h want %h", name, cyc, cur, e);
            end
            if (cyc == stop_at) break;
            st[sel] = (cyc == mid);
            if (sb.size() > 0) @(negedge clk);
            cyc++;
        end
        st[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            sel = i;
            #1;
            nvec++;
            if (cur !== '0) begin
                nerr++;
                $display("FAIL reset_state inst%0d: got %h want %h", i, cur, obs_t'('0));
            end
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_correct();
        sel = 0; fault = 0;
        build(10, 1, 0);
        run("correct", -1, -1, 1'b0);
    endtask

    task automatic test_stuck0();
        sel = 0; fault = 1;
        build(10, 1, 1);
        run("stuck0", -1, -1, 1'b1);
        fault = 0;
    endtask

    task automatic test_hold3();
        sel = 1; fault = 0;
        build(4, 3, 0);
        run("hold3", -1, -1, 1'b0);
        sel = 0;
    endtask

    task automatic test_abort();
        sel = 0; fault = 1;
        build(10, 1, 1);
        run("abort_run", -1, 11, 1'b1);
        sb.delete();
        #2 rst = 1'b0;
        #1;
        nvec++;
        if (cur !== '0) begin
            nerr++;
            $display("FAIL abort_outputs: got %h want %h", cur, obs_t'('0));
        end
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        nvec++;
        if (cur !== '0) begin
            nerr++;
            $display("FAIL start_at_release: got %h want %h", cur, obs_t'('0));
        end
        fault = 0;
        build(10, 1, 0);
        run("after_abort", -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 0; fault = 0;
        build(10, 1, 0);
        run("mid_start", 3, -1, 1'b1);
        build(10, 1, 0);
        run("restart", -1, -1, 1'b1);
    endtask

`ifdef SR_ILLEGAL_TEST_EN
    task automatic test_illegal();
        sel = 2; fault = 2;
        build(8, 1, 2);
        run("illegal", -1, -1, 1'b0);
        fault = 0; sel = 0;
    endtask
`endif

    initial begin
        nvec = 0; nerr = 0; sel = 0; fault = 0; st = '0; rst = 1'b0;
        test_reset();
        test_correct();
        test_stuck0();
        test_hold3();
        test_abort();
        test_back_to_back();
`ifdef SR_ILLEGAL_TEST_EN
        test_illegal();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sr_stim_checker.md
Name: sr_stim_checker

Overview:
- Hardware-side counterpart to an SR flip-flop under test: generates the s/r command stream, pulses the DUT reset, and checks returned q against an internal golden model.
- Sits beside any srflipflop-style cell on the same clk, for self-checking on FPGA or in sim without a behavioural bench.
- Sequence per run: DUT reset, then NUM_VECTORS vectors cycling 00 -> 01 -> 10 -> 00 ... on {s,r}.
- Reports mismatch count and pass/fail.

Parameters:
- NUM_VECTORS, 10, vectors applied per run (1..2^CNT_W-1).
- HOLD_CYCLES, 1, cycles each vector is driven before the check cycle (>=1).
- CNT_W, 8, width of vec_idx and err_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle run request; ignored unless state is IDLE or DONE.
- dut_rst  output  1  active-high reset to DUT.
- s_out  output  1  set command to DUT.
- r_out  output  1  reset command to DUT.
- q_in  input  1  DUT q output.
- busy  output  1  high in INIT, DRIVE, CHECK.
- done  output  1  high in DONE until next accepted start.
- pass  output  1  done && err_count==0.
- vec_idx  output  CNT_W  index of current or last vector.
- err_count  output  CNT_W  mismatches this run; saturates at all-ones.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - All outputs 0: s_out, r_out, dut_rst, busy, done, pass, vec_idx, err_count.
  - Pattern index pat=0; expected model exp_q=0.
- Reset asserted mid-run aborts immediately; after release, no run resumes until a new start.
- IDLE/DONE + start=1 -> INIT (next edge):
  - Clear err_count and vec_idx; pat=0.
  - done stays high during the start cycle, then falls.
- INIT, exactly 1 cycle:
  - dut_rst=1, s_out=r_out=0, exp_q<=0.
  - Next state DRIVE.
- DRIVE, HOLD_CYCLES cycles (internal hold counter):
  - {s_out,r_out} = pattern[pat]; pattern 0={0,0}, 1={0,1}, 2={1,0}.
  - On the entry edge, exp_q updates: 00 keeps, 01 -> 0, 10 -> 1.
  - After the last hold cycle -> CHECK.
- CHECK, 1 cycle:
  - s/r still held.
  - At the closing edge, compare q_in to exp_q; on mismatch err_count++ (saturating).
  - If vec_idx==NUM_VECTORS-1 -> DONE, with s_out=r_out=0.
  - Else vec_idx++, pat wraps 2 -> 0, -> DRIVE.
- Latency:
  - A vector is visible on s/r for HOLD_CYCLES+1 cycles.
  - Run length = 1 + NUM_VECTORS*(HOLD_CYCLES+1) cycles from INIT to DONE.
- DONE: s_out=r_out=dut_rst=0; done=1; pass valid; err_count and vec_idx frozen.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle as reset release is ignored (reset dominates).
- {s_out,r_out}=11 is never driven unless the optional feature is enabled.

Optional Feature:
- Macro: SR_ILLEGAL_TEST_EN.
- Defined:
  - Pattern sequence extends to 00, 01, 10, 11, wrapping 3 -> 0.
  - On 11, exp_q becomes don't-care: the CHECK compare is masked (no err_count change).
  - exp_q stays unknown until the next 01 or 10 vector re-establishes it; compares on intervening 00 vectors are also masked.
- Undefined: 3-entry sequence only; 11 unreachable; no masking logic synthesised.

Test Plan:
- Correct DUT, defaults, start pulse:
  - Run takes 21 cycles INIT->DONE.
  - s/r sequence 00,01,10,00,01,10,00,01,10,00.
  - done=1, err_count=0, pass=1, vec_idx=9.
- DUT q stuck at 0, defaults:
  - Mismatches at vectors 2, 3, 5, 6, 8, 9.
  - err_count=6, pass=0.
- HOLD_CYCLES=3, NUM_VECTORS=4, correct DUT:
  - Each vector held 4 cycles; run length 17 cycles.
  - pass=1.
- rst driven low during vector 5, released 3 cycles later:
  - All outputs 0 immediately, state IDLE.
  - A new start runs from vec_idx=0 with err_count cleared.
- start pulsed during DRIVE:
  - No effect; run completes with the same timing as test 1.
  - A second start in DONE restarts the run.
- SR_ILLEGAL_TEST_EN defined, NUM_VECTORS=8, DUT q forced 1 on 11 and held afterwards:
  - Vector 3 (11) compare masked.
  - Vector 4 (00) compare masked.
  - Vector 5 (01) compared normally, expected 0; the forced-1 DUT gives a mismatch.
  - err_count=1 for that fault.
